// File: rtl/fpu_alu_unit.sv
// Multi-cycle FPU helper: sign ops, compares, and float/int conversions with a
// programmable result latency and an IDLE/BUSY/DONE handshake.
module fpu_alu_unit #(
  parameter int LATENCY  = 2,
  parameter int SATURATE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  input  logic [31:0] rs,
  output logic        ready,
  output logic        completed,
  output logic [31:0] out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  localparam logic [2:0] OP_FMOV = 3'd0;
  localparam logic [2:0] OP_FNEG = 3'd1;
  localparam logic [2:0] OP_FABS = 3'd2;
  localparam logic [2:0] OP_FEQ  = 3'd3;
  localparam logic [2:0] OP_FLT  = 3'd4;
  localparam logic [2:0] OP_FLE  = 3'd5;
  localparam logic [2:0] OP_FTOI = 3'd6;
  localparam logic [2:0] OP_ITOF = 3'd7;

  logic [1:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic [2:0]  op_reg;
  logic [31:0] fs_reg;
  logic [31:0] ft_reg;
  logic [31:0] rs_reg;
  logic [31:0] out_reg;
  logic        completed_reg;
  logic [31:0] result_next;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotonic unsigned key: both zeros map to the same point, negatives fold below.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[30:0] == 31'd0)
      return 32'h8000_0000;
    else if (x[31])
      return ~x;
    else
      return {1'b1, x[30:0]};
  endfunction

  function automatic logic [31:0] ftoi(input logic [31:0] x);
    logic [7:0]  e;
    logic [31:0] sig;
    logic [31:0] mag;
    logic [31:0] ovf;
    e   = x[30:23];
    sig = {8'h00, 1'b1, x[22:0]};
    if (SATURATE != 0)
      ovf = is_nan(x) ? 32'h0 : (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    else
      ovf = 32'h8000_0000;
    if (e == 8'hFF || e >= 8'd158)
      return ovf;
    else if (e < 8'd127)
      return 32'h0;
    else begin
      if (e >= 8'd150)
        mag = sig << (e - 8'd150);
      else
        mag = sig >> (8'd150 - e);
      return x[31] ? (~mag + 32'd1) : mag;
    end
  endfunction

  function automatic logic [31:0] itof(input logic [31:0] v);
    logic [31:0] mag;
    logic [4:0]  p;
    logic [30:0] norm;
    logic [30:0] body;
    logic        rnd;
    mag = v[31] ? (~v + 32'd1) : v;
    p   = 5'd0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) p = 5'(i);
    // Leading one lands at bit 31 and is dropped; norm[30:8] is the mantissa.
    norm = 31'(mag << (5'd31 - p));
    rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
    body = {8'd127 + {3'b000, p}, norm[30:8]} + {30'd0, rnd};
    if (v == 32'd0)
      return 32'h0;
    else
      return {v[31], body};
  endfunction

  always_comb begin
    result_next = 32'h0;
    case (op_reg)
      OP_FMOV: result_next = fs_reg;
      OP_FNEG: result_next = {~fs_reg[31], fs_reg[30:0]};
      OP_FABS: result_next = {1'b0, fs_reg[30:0]};
      OP_FEQ:  result_next = {31'd0, !is_nan(fs_reg) && !is_nan(ft_reg) &&
                                     (order_key(fs_reg) == order_key(ft_reg))};
      OP_FLT:  result_next = {31'd0, !is_nan(fs_reg) && !is_nan(ft_reg) &&
                                     (order_key(fs_reg) < order_key(ft_reg))};
      OP_FLE:  result_next = {31'd0, !is_nan(fs_reg) && !is_nan(ft_reg) &&
                                     (order_key(fs_reg) <= order_key(ft_reg))};
      OP_FTOI: result_next = ftoi(fs_reg);
      OP_ITOF: result_next = itof(rs_reg);
      default: result_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 3'd0;
      op_reg        <= 3'd0;
      fs_reg        <= 32'h0;
      ft_reg        <= 32'h0;
      rs_reg        <= 32'h0;
      out_reg       <= 32'h0;
      completed_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_reg        <= op;
            fs_reg        <= fs;
            ft_reg        <= ft;
            rs_reg        <= rs;
            completed_reg <= 1'b0;
            cnt_reg       <= CNT_INIT;
            state_reg     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_reg == 3'd0) begin
            out_reg       <= result_next;
            completed_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state_reg != ST_BUSY);
  assign completed = completed_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_fpu_alu_unit.sv
// Scoreboard bench: two instances (saturating and non-saturating FTOI) share
// stimulus; monitors compare each completion against queued expectations.
module tb_fpu_alu_unit;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] fs = 32'h0;
  logic [31:0] ft = 32'h0;
  logic [31:0] rs = 32'h0;
  logic        ready_a, completed_a, ready_b, completed_b;
  logic [31:0] out_a, out_b;

  typedef struct {
    logic [31:0] value;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fpu_alu_unit #(.LATENCY(LAT), .SATURATE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .op(op), .fs(fs), .ft(ft), .rs(rs),
    .ready(ready_a), .completed(completed_a), .out(out_a)
  );

  fpu_alu_unit #(.LATENCY(LAT), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .op(op), .fs(fs), .ft(ft), .rs(rs),
    .ready(ready_b), .completed(completed_b), .out(out_b)
  );

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (completed_a && !prev_a) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL sat1_unexpected_completion actual out=%h cycle=%0d required no completion", out_a, cycle);
      end else begin
        e = q_a.pop_front();
        if (out_a !== e.value || cycle != e.due) begin
          failures++;
          $display("FAIL sat1_result actual out=%h cycle=%0d required out=%h cycle=%0d", out_a, cycle, e.value, e.due);
        end else
          $display("txn sat1 out=%h cycle=%0d ok", out_a, cycle);
      end
    end
    prev_a = completed_a;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (completed_b && !prev_b) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL sat0_unexpected_completion actual out=%h cycle=%0d required no completion", out_b, cycle);
      end else begin
        e = q_b.pop_front();
        if (out_b !== e.value || cycle != e.due) begin
          failures++;
          $display("FAIL sat0_result actual out=%h cycle=%0d required out=%h cycle=%0d", out_b, cycle, e.value, e.due);
        end else
          $display("txn sat0 out=%h cycle=%0d ok", out_b, cycle);
      end
    end
    prev_b = completed_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready_a && ready_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(ready_a && ready_b)) check("ready_timeout", 32'(ready_a & ready_b), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(completed_a && completed_b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(completed_a && completed_b)) check("done_timeout", 32'(completed_a & completed_b), 32'd1);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [31:0] ea, input logic [31:0] eb,
                       input bit hold);
    exp_t e;
    wait_ready();
    op = o; fs = a; ft = b; rs = r; start = 1'b1;
    e.due = cycle + 1 + LAT;
    e.value = ea; q_a.push_back(e);
    e.value = eb; q_b.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic [31:0] ea, input logic [31:0] eb);
    issue(o, a, b, r, ea, eb, 1'b0);
    check("b2b_completed_drop", 32'(completed_a), 32'd0);
    wait_done();
  endtask

  initial begin
    #1;
    check("reset_ready", 32'(ready_a), 32'd1);
    check("reset_completed", 32'(completed_a), 32'd0);
    check("reset_out", out_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First start right after reset release, then a start held through BUSY.
    run(3'd0, 32'h7FC1_2345, 32'h0, 32'h0, 32'h7FC1_2345, 32'h7FC1_2345);
    issue(3'd1, 32'h3F80_0000, 32'h0, 32'h0, 32'hBF80_0000, 32'hBF80_0000, 1'b1);
    fs = 32'h1234_5678; op = 3'd0;
    @(posedge clk); @(negedge clk);
    check("busy_ready_edge1", 32'(ready_a), 32'd0);
    @(posedge clk); @(negedge clk);
    check("busy_ready_edge2", 32'(ready_a), 32'd0);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("done_hold_completed", 32'(completed_a), 32'd1);
    check("done_hold_out", out_a, 32'hBF80_0000);

    run(3'd2, 32'hFFC0_0001, 32'h0, 32'h0, 32'h7FC0_0001, 32'h7FC0_0001);
    run(3'd4, 32'h8000_0000, 32'h0000_0000, 32'h0, 32'h0, 32'h0);
    run(3'd5, 32'h8000_0000, 32'h0000_0000, 32'h0, 32'h1, 32'h1);
    run(3'd3, 32'h7FC0_0000, 32'h7FC0_0000, 32'h0, 32'h0, 32'h0);
    run(3'd3, 32'h8000_0000, 32'h0000_0000, 32'h0, 32'h1, 32'h1);
    run(3'd4, 32'h0000_0001, 32'h0000_0002, 32'h0, 32'h1, 32'h1);
    run(3'd4, 32'hBF80_0000, 32'h3F80_0000, 32'h0, 32'h1, 32'h1);
    run(3'd4, 32'hC000_0000, 32'hBF80_0000, 32'h0, 32'h1, 32'h1);
    run(3'd5, 32'h4000_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);
    run(3'd6, 32'h4030_0000, 32'h0, 32'h0, 32'h0000_0002, 32'h0000_0002);
    run(3'd6, 32'hC030_0000, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    run(3'd6, 32'h5015_02F9, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000);
    run(3'd6, 32'hCF00_0000, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000);
    run(3'd6, 32'hFF80_0000, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000);
    run(3'd6, 32'h7FC0_0000, 32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000);
    run(3'd6, 32'h3F7F_FFFF, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0000);
    run(3'd6, 32'h4EFF_FFFF, 32'h0, 32'h0, 32'h7FFF_FF80, 32'h7FFF_FF80);
    run(3'd6, 32'h4F00_0000, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000);
    run(3'd7, 32'h0, 32'h0, 32'd16777217, 32'h4B80_0000, 32'h4B80_0000);
    run(3'd7, 32'h0, 32'h0, 32'd16777219, 32'h4B80_0002, 32'h4B80_0002);
    run(3'd7, 32'h0, 32'h0, 32'd16777221, 32'h4B80_0002, 32'h4B80_0002);
    run(3'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000);
    run(3'd7, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    run(3'd7, 32'h0, 32'h0, 32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000);
    run(3'd7, 32'h0, 32'h0, 32'd7, 32'h40E0_0000, 32'h40E0_0000);

    // Asynchronous reset in the middle of BUSY; the abandoned op must never complete.
    issue(3'd1, 32'h4000_0000, 32'h0, 32'h0, 32'hC000_0000, 32'hC000_0000, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midbusy_ready", 32'(ready_a), 32'd1);
    check("midbusy_completed", 32'(completed_a), 32'd0);
    check("midbusy_out", out_a, 32'h0);
    check("midbusy_out_sat0", out_b, 32'h0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("no_completion_after_reset", 32'(completed_a), 32'd0);
    run(3'd2, 32'hC0A0_0000, 32'h0, 32'h0, 32'h40A0_0000, 32'h40A0_0000);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_alu_unit.md
FPU_ALU_UNIT -- requirements
Module: fpu_alu_unit

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from accepted start to result valid; legal range 1..8.
REQ-002 SHALL have parameter SATURATE, default 1, meaning 1 = clamp out-of-range FTOI results and 0 = return 0x80000000.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port op  input  3  operation select: 0 FMOV, 1 FNEG, 2 FABS, 3 FEQ, 4 FLT, 5 FLE, 6 FTOI, 7 ITOF.
REQ-007 SHALL have port fs  input  32  first IEEE-754 single operand.
REQ-008 SHALL have port ft  input  32  second single operand (compares only).
REQ-009 SHALL have port rs  input  32  two's-complement integer operand (ITOF only).
REQ-010 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-011 SHALL have port completed  output  1  high while out holds a valid result.
REQ-012 SHALL have port out  output  32  result.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; ready=1 in IDLE and DONE, 0 in BUSY.
REQ-014 SHALL, on an edge with start=1 and ready=1, latch op/fs/ft/rs, clear completed, load a down-counter with LATENCY-1, and enter BUSY.
REQ-015 SHALL decrement the counter each BUSY edge and, on the edge where it equals 0, drive out with the result, set completed=1, and enter DONE, giving completed high after exactly LATENCY edges from acceptance.
REQ-016 SHALL ignore start while BUSY; latched operands SHALL NOT change and no request SHALL be queued.
REQ-017 SHALL hold out and completed stable in DONE until the next accepted start; a start in DONE restarts per REQ-014 on that edge.
REQ-018 SHALL ignore input changes other than at acceptance.
REQ-019 FMOV: out=fs; FNEG: out=fs with bit31 inverted; FABS: out=fs with bit31 cleared; all bit-exact, including NaN payloads.
REQ-020 FEQ/FLT/FLE: out=32'h1 when true, 32'h0 otherwise; any NaN operand gives 0; +0 and -0 compare equal; denormals compare by value.
REQ-021 FTOI: truncate toward zero; |fs|<1 and denormals give 0.
REQ-022 FTOI out-of-range (value ≥2^31 or <-2^31) with SATURATE=1: 0x7FFFFFFF for positive/+inf, 0x80000000 for negative/-inf, 0 for NaN; with SATURATE=0: 0x80000000 for all out-of-range, inf and NaN.
REQ-023 FTOI of exactly -2^31 (0xCF000000) SHALL give 0x80000000 in both modes.
REQ-024 ITOF: round to nearest, ties to even; 0 gives 0x00000000; 0x80000000 gives 0xCF000000.

Reset
REQ-025 SHALL, while reset=1, immediately force state=IDLE, ready=1, completed=0, out=0, counter=0, regardless of clk.
REQ-026 SHALL abandon any BUSY operation on reset and produce no completion for it after release.
REQ-027 SHALL accept a start on the first rising edge after reset deasserts.

Verification
REQ-028 LATENCY=3: start, op=FNEG, fs=0x3F800000 at edge 0 -> ready=0 after edges 1-2; completed=1, out=0xBF800000 after edge 3; start held high during BUSY is ignored.
REQ-029 FLT fs=0x80000000, ft=0x00000000 -> out=0; FLE same -> 1; FEQ fs=0x7FC00000, ft=0x7FC00000 -> 0.
REQ-030 FTOI fs=0x40300000 (2.75) -> 0x00000002; fs=0xC0300000 -> 0xFFFFFFFE; fs=0x501502F9 (1e10) -> 0x7FFFFFFF with SATURATE=1 and 0x80000000 with SATURATE=0.
REQ-031 ITOF rs=16777217 -> 0x4B800000; rs=16777219 -> 0x4B800002; rs=0xFFFFFFFF -> 0xBF800000.
REQ-032 Reset asserted mid-BUSY between edges -> ready=1, completed=0, out=0 without a clock edge; no completion after release; a new start then completes normally.
REQ-033 A back-to-back start in the DONE cycle -> completed drops on the same edge and the new result appears LATENCY edges later.
